// File: rtl/ika_noise_mc.sv
// Multi-channel noise generator: per-channel divider, right-shift LFSR,
// formatted signed samples for the operator accumulator, serial LFO tap.
module ika_noise_mc #(
    parameter int                  NUM_CH    = 4,
    parameter int                  LFSR_W    = 16,
    parameter int                  FREQ_W    = 5,
    parameter int                  TAP_WHITE = 2,
    parameter int                  TAP_SHORT = 1,
    parameter int                  PAR_W     = 9,
    parameter logic [LFSR_W-1:0]   SEED      = LFSR_W'(1),
    localparam int                 OUT_W     = PAR_W + 5
) (
    input  logic                       i_EMUCLK,
    input  logic                       i_MRST,
    input  logic                       i_CEN_n,
    input  logic                       i_TICK,
    input  logic [NUM_CH-1:0]          i_EN,
    input  logic [NUM_CH-1:0]          i_MODE,
    input  logic [NUM_CH*FREQ_W-1:0]   i_NFRQ,
    input  logic [NUM_CH-1:0]          i_RESEED,
    input  logic [NUM_CH-1:0]          i_ATTEN_MAX,
    output logic [NUM_CH*OUT_W-1:0]    o_NOISE,
    output logic [NUM_CH-1:0]          o_STEP,
    output logic                       o_LFO_NOISE
);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [LFSR_W-1:0] q;
        logic [FREQ_W-1:0] cnt;
        logic [OUT_W-1:0]  sample_r;
        logic              step_r;

        logic [LFSR_W-1:0] seed;
        logic [FREQ_W-1:0] frq;
        logic              hit;
        logic              step;
        logic              tap;
        logic              fb;
        logic              s;
        logic [PAR_W-1:0]  p;
        logic [OUT_W-1:0]  sample;

        assign seed = SEED + LFSR_W'(c);
        assign frq  = i_NFRQ[c*FREQ_W +: FREQ_W];
        assign hit  = i_TICK && (cnt == ~frq);
        assign step = i_EN[c] && !i_RESEED[c] && hit;

        // all-zero state would lock up, so feed a one back in
        assign tap = i_MODE[c] ? q[TAP_SHORT] : q[TAP_WHITE];
        assign fb  = (q == '0) ? 1'b1 : (q[0] ^ tap);

        assign s = q[0];
        assign p = q[PAR_W:1] ^ {PAR_W{s}};

        always_comb begin
            sample = '0;
            if (i_EN[c] && !i_ATTEN_MAX[c])
                sample = {s, s, p, s, s, s};
        end

        always_ff @(posedge i_EMUCLK or posedge i_MRST) begin
            if (i_MRST) begin
                q        <= seed;
                cnt      <= '0;
                sample_r <= '0;
                step_r   <= 1'b0;
            end else if (!i_CEN_n) begin
                if (!i_EN[c] || i_RESEED[c])
                    cnt <= '0;
                else if (hit)
                    cnt <= '0;
                else if (i_TICK)
                    cnt <= cnt + 1'b1;

                if (i_RESEED[c])
                    q <= seed;
                else if (step)
                    q <= {fb, q[LFSR_W-1:1]};

                sample_r <= sample;
                step_r   <= step;
            end
        end

        assign o_NOISE[c*OUT_W +: OUT_W] = sample_r;
        assign o_STEP[c]                 = step_r;
    end

    assign o_LFO_NOISE = g_ch[0].q[1];

endmodule

// File: tb/tb_ika_noise_mc.sv
// Scoreboard bench for ika_noise_mc: two instances (seed base 1 and 0)
// share stimulus; a reference model queues expected outputs per cycle.
module tb_ika_noise_mc;

    localparam int NC = 4;
    localparam int FW = 5;
    localparam int OW = 14;
    localparam int NW = NC * OW;

    logic          clk;
    logic          rst;
    logic          cen_n;
    logic          tick;
    logic [NC-1:0] en;
    logic [NC-1:0] mode;
    logic [NC*FW-1:0] nfrq;
    logic [NC-1:0] reseed;
    logic [NC-1:0] atten;

    logic [NW-1:0] noise0, noise1;
    logic [NC-1:0] step0, step1;
    logic          lfo0, lfo1;

    ika_noise_mc #(.NUM_CH(NC), .LFSR_W(16), .FREQ_W(FW), .TAP_WHITE(2),
                   .TAP_SHORT(1), .PAR_W(9), .SEED(16'h0001)) u0 (
        .i_EMUCLK(clk), .i_MRST(rst), .i_CEN_n(cen_n), .i_TICK(tick),
        .i_EN(en), .i_MODE(mode), .i_NFRQ(nfrq), .i_RESEED(reseed),
        .i_ATTEN_MAX(atten), .o_NOISE(noise0), .o_STEP(step0),
        .o_LFO_NOISE(lfo0)
    );

    ika_noise_mc #(.NUM_CH(NC), .LFSR_W(16), .FREQ_W(FW), .TAP_WHITE(2),
                   .TAP_SHORT(1), .PAR_W(9), .SEED(16'h0000)) uz (
        .i_EMUCLK(clk), .i_MRST(rst), .i_CEN_n(cen_n), .i_TICK(tick),
        .i_EN(en), .i_MODE(mode), .i_NFRQ(nfrq), .i_RESEED(reseed),
        .i_ATTEN_MAX(atten), .o_NOISE(noise1), .o_STEP(step1),
        .o_LFO_NOISE(lfo1)
    );

    typedef struct {
        logic [NW-1:0] noise [2];
        logic [NC-1:0] step [2];
        logic          lfo [2];
    } exp_t;

    exp_t sb [$];
    int   checks = 0;
    int   errors = 0;

    logic [15:0]   mq [2][NC];
    logic [FW-1:0] mc [2][NC];
    logic [NW-1:0] e_noise [2];
    logic [NC-1:0] e_step [2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(string name, logic [63:0] act, logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, expv);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int c = 0; c < NC; c++) begin
                mq[k][c] = (k == 0 ? 16'h0001 : 16'h0000) + 16'(c);
                mc[k][c] = '0;
            end
            e_noise[k] = '0;
            e_step[k]  = '0;
        end
    endtask

    task automatic model_cycle();
        exp_t e;
        if (!cen_n) begin
            for (int k = 0; k < 2; k++) begin
                for (int c = 0; c < NC; c++) begin
                    logic [15:0] q;
                    logic s, hit, stp, fb;
                    logic [8:0] p;
                    logic [FW-1:0] f;
                    logic [OW-1:0] smp;
                    int t;
                    q = mq[k][c];
                    s = q[0];
                    p = q[9:1] ^ {9{s}};
                    smp = (atten[c] || !en[c]) ? '0 : {s, s, p, s, s, s};
                    e_noise[k][c*OW +: OW] = smp;
                    f = nfrq[c*FW +: FW];
                    hit = tick && (mc[k][c] == ~f);
                    stp = en[c] && !reseed[c] && hit;
                    if (!en[c] || reseed[c]) mc[k][c] = '0;
                    else if (hit) mc[k][c] = '0;
                    else if (tick) mc[k][c] = mc[k][c] + 1'b1;
                    t = mode[c] ? 1 : 2;
                    fb = (q == 16'h0) ? 1'b1 : (q[0] ^ q[t]);
                    if (reseed[c])
                        mq[k][c] = (k == 0 ? 16'h0001 : 16'h0000) + 16'(c);
                    else if (stp)
                        mq[k][c] = {fb, q[15:1]};
                    e_step[k][c] = stp;
                end
            end
        end
        for (int k = 0; k < 2; k++) begin
            e.noise[k] = e_noise[k];
            e.step[k]  = e_step[k];
            e.lfo[k]   = mq[k][0][1];
        end
        sb.push_back(e);
    endtask

    task automatic cyc();
        model_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("noise_u0", 64'(noise0), 64'(e.noise[0]));
            chk("step_u0", 64'(step0), 64'(e.step[0]));
            chk("lfo_u0", 64'(lfo0), 64'(e.lfo[0]));
            chk("noise_uz", 64'(noise1), 64'(e.noise[1]));
            chk("step_uz", 64'(step1), 64'(e.step[1]));
            chk("lfo_uz", 64'(lfo1), 64'(e.lfo[1]));
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout at %0t", $time);
        $fatal(1);
    end

    initial begin
        int n0, n1;
        rst = 1'b1; cen_n = 1'b0; tick = 1'b0; en = '0; mode = '0;
        nfrq = '0; reseed = '0; atten = '0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        chk("rst_noise_u0", 64'(noise0), 64'h0);
        chk("rst_step_u0", 64'(step0), 64'h0);
        chk("rst_lfo_u0", 64'(lfo0), 64'h0);
        chk("rst_noise_uz", 64'(noise1), 64'h0);
        rst = 1'b0;

        // disabled: no steps, silent
        tick = 1'b1;
        for (int i = 0; i < 10; i++) cyc();

        // seeds 1..4 visible as formatted samples
        en = 4'hF; tick = 1'b0;
        cyc();
        chk("seed_samples", 64'(noise0),
            64'({14'h0010, 14'h3FF7, 14'h0008, 14'h3FFF}));

        // rate: ch0 every tick, ch1 once per 32 ticks
        nfrq = {5'd17, 5'd5, 5'd0, 5'd31};
        tick = 1'b1;
        n0 = 0; n1 = 0;
        for (int i = 0; i < 64; i++) begin
            cyc();
            if (step0[0]) n0++;
            if (step0[1]) n1++;
        end
        chk("rate_ch0", 64'(n0), 64'd64);
        chk("rate_ch1", 64'(n1), 64'd2);

        // periodic mode, mid-count frequency change
        mode = 4'b0001;
        nfrq[3*FW +: FW] = 5'd2;
        for (int i = 0; i < 12; i++) cyc();
        mode = 4'b0000;
        for (int i = 0; i < 20; i++) cyc();

        // mute channel 2 only
        atten = 4'b0100;
        for (int i = 0; i < 20; i++) cyc();
        atten = '0;

        // reseed on a step cycle: no pulse, seed reloaded
        reseed = 4'b0011;
        cyc();
        chk("reseed_nostep", 64'(step0[0]), 64'h0);
        reseed = '0; tick = 1'b0;
        cyc();
        chk("reseed_sample", 64'(noise0[0 +: OW]), 64'h3FFF);
        tick = 1'b1;
        for (int i = 0; i < 10; i++) cyc();

        // clock-enable gating freezes everything
        cen_n = 1'b1;
        for (int i = 0; i < 10; i++) cyc();
        cen_n = 1'b0;
        for (int i = 0; i < 30; i++) cyc();

        // async reset mid-operation
        #2 rst = 1'b1;
        #1;
        chk("arst_noise_u0", 64'(noise0), 64'h0);
        chk("arst_step_u0", 64'(step0), 64'h0);
        chk("arst_noise_uz", 64'(noise1), 64'h0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 40; i++) cyc();
        en = 4'b1010;
        for (int i = 0; i < 10; i++) cyc();

        @(posedge clk);
        #2;
        chk("sb_drain", 64'(sb.size()), 64'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ika_noise_mc.md
Name: ika_noise_mc

Overview:
Multi-channel, parametrised noise generator for the IKA sound cores. It is the successor to the single-channel OPM noise block. Each channel has its own frequency divider, a Galois-free right-shift LFSR with selectable white/periodic feedback tap, lockup recovery, synchronous reseed, and a mute/enable gate. Channel 0 also drives a serial bit stream for LFO use. Formatted parallel samples feed the operator accumulator.

Parameters:
NUM_CH, 4, number of independent noise channels
LFSR_W, 16, LFSR width (>= PAR_W+2)
FREQ_W, 5, divider/frequency register width
TAP_WHITE, 2, feedback tap index used in white mode
TAP_SHORT, 1, feedback tap index used in periodic mode
PAR_W, 9, parallel magnitude bits per sample; sample width OUT_W = PAR_W+5
SEED, 16'h0001, LFSR reset/reseed value base

Ports:
i_EMUCLK  in  1  master clock
i_MRST  in  1  reset, asynchronous, active-high
i_CEN_n  in  1  clock enable, active-low; all state advances only when 0
i_TICK  in  1  divider advance qualifier, sampled with i_CEN_n=0
i_EN  in  NUM_CH  per-channel enable
i_MODE  in  NUM_CH  per-channel mode: 0 = white (TAP_WHITE), 1 = periodic (TAP_SHORT)
i_NFRQ  in  NUM_CH*FREQ_W  per-channel frequency; channel c uses bits [c*FREQ_W +: FREQ_W]
i_RESEED  in  NUM_CH  per-channel synchronous reseed strobe
i_ATTEN_MAX  in  NUM_CH  per-channel mute request (attenuation at max)
o_NOISE  out  NUM_CH*OUT_W  per-channel formatted signed samples, registered
o_STEP  out  NUM_CH  per-channel one-cycle pulse when that channel's LFSR advanced
o_LFO_NOISE  out  1  channel 0 LFSR bit 1, serial

Behaviour:
- Reset (async, i_MRST=1) values:
  - channel c LFSR = (SEED + c) mod 2^LFSR_W; divider = 0.
  - o_NOISE = 0; o_STEP = 0.
  - o_LFO_NOISE follows LFSR ch0 bit 1 (= SEED bit 1 at reset).
- No register changes on any cycle with i_CEN_n=1. The conditions below are evaluated only on enabled cycles.
- Divider, per channel:
  - If !i_EN[c] or i_RESEED[c]: cnt <= 0, no step.
  - Else if i_TICK and cnt == ~NFRQ: cnt <= 0, step = 1.
  - Else if i_TICK: cnt <= cnt + 1 (FREQ_W bits, wraps).
  - Resulting step period = 2^FREQ_W - NFRQ ticks. NFRQ = all-ones gives a step every tick; NFRQ = 0 gives a step every 2^FREQ_W ticks.
  - An NFRQ change mid-count takes effect at the next compare. If cnt has already passed the new ~NFRQ, it wraps through 2^FREQ_W first.
- LFSR, on step:
  - q <= {fb, q[LFSR_W-1:1]}, where tap t = i_MODE[c] ? TAP_SHORT : TAP_WHITE and fb = q[0] ^ q[t].
  - Lockup recovery: if q == 0, fb is forced to 1.
  - A mode change applies at the next step; the LFSR is not cleared.
- Reseed: i_RESEED[c] loads SEED + c and clears cnt. It has priority over a coincident step, and o_STEP[c] stays 0 that cycle.
- o_STEP[c]: registered, high for exactly the enabled cycle following the edge where the step occurred.
- Output, registered every enabled cycle from the current LFSR state (one enabled cycle latency after a step):
  - s = q[0]; p = q[PAR_W:1] ^ {PAR_W{s}}.
  - Muted (i_ATTEN_MAX[c]=1) or disabled (i_EN[c]=0): sample = 0.
  - Otherwise: sample = {s, s, p, s, s, s}.
- Channels are fully independent: one channel's enable, reseed or mute never affects another.
- Reset asserted mid-operation clears everything immediately. After release, the first step occurs 2^FREQ_W - NFRQ ticks later.

Test Plan:
- Reset/seed: assert i_MRST, NUM_CH=4, SEED=1 -> LFSRs = 1,2,3,4; o_NOISE=0; o_STEP=0. Release, hold i_EN=0 -> no steps, o_NOISE stays 0.
- Rate: ch0 NFRQ=31, ch1 NFRQ=0, i_TICK=1 continuously -> o_STEP[0] every tick; o_STEP[1] once per 32 ticks.
- Sequence: ch0 white, SEED=1, 20 steps -> LFSR states match a reference model using fb=q0^q2. Sample format for q=16'h0003 is {1,1,9'h1FE,1,1,1} (p = q[9:1] ^ all-ones = 9'h1FE).
- Lockup/reseed: force q=0 via SEED=0 -> first step yields 16'h8000. Assert i_RESEED on a step cycle -> seed loaded, no o_STEP.
- Mute: i_ATTEN_MAX[2]=1 while running -> o_NOISE ch2 = 0 from the next enabled cycle; other channels unaffected; LFSR ch2 keeps stepping.
- Gating: hold i_CEN_n=1 for 10 cycles with i_TICK=1 -> all state frozen. Async reset mid-count -> immediate clear.
